// File: rtl/keypad_bcd_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types, widths and helper functions for the keypad BCD
//            encoder (debounce FSM state type, key/BCD widths, one-hot helpers).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;
  localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Exactly one key down; zero keys and chords are both rejected.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] k);
    return ($countones(k) == 1);
  endfunction

  // Index of the set bit. Only meaningful when is_onehot() holds.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] k);
    logic [BCD_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) bcd = BCD_W'(i);
    end
    return bcd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_bcd_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_if
// Purpose  : Bundles the keypad inputs and BCD time outputs of the encoder.
// Ports    : key[9:0], clear, lock          (master -> slave)
//            min, sec_tens, sec_ones [3:0],
//            digit_strobe, time_valid       (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_if;
  import keypad_pkg::*;

  logic [NUM_KEYS-1:0] key;
  logic                clear;
  logic                lock;
  logic [BCD_W-1:0]    min;
  logic [BCD_W-1:0]    sec_tens;
  logic [BCD_W-1:0]    sec_ones;
  logic                digit_strobe;
  logic                time_valid;

  modport master (
    output key, clear, lock,
    input  min, sec_tens, sec_ones, digit_strobe, time_valid
  );

  modport slave (
    input  key, clear, lock,
    output min, sec_tens, sec_ones, digit_strobe, time_valid
  );

endinterface
`default_nettype wire

// File: rtl/keypad_bcd_encoder_debounce.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce
// Purpose  : Press/release debounce FSM. Emits a single combinational
//            press_pulse on the edge a stable press is accepted, so the
//            caller's registers update on that same edge.
// Ports    : clk, rst_n (sync, active-low), key[9:0], lock,
//            press_pulse, press_code[3:0]
// Revision : 1.0 - initial release
// ============================================================================
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                lock,
  output logic                press_pulse,
  output logic [BCD_W-1:0]    press_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BCD_W-1:0] code, code_nxt;
  logic             valid_key;
  logic [BCD_W-1:0] key_code;

  assign valid_key = is_onehot(key);
  assign key_code  = onehot_to_bcd(key);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    code_nxt    = code;
    press_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (valid_key && !lock) begin
          code_nxt = key_code;
          cnt_nxt  = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            press_pulse = 1'b1;
            state_nxt   = HELD;
          end else begin
            state_nxt = PRESS;
          end
        end
      end
      PRESS: begin
        // lock on the final sample still aborts the press.
        if (!valid_key || lock) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (key_code == code) begin
          cnt_nxt = cnt + CNT_ONE;
          if (cnt_nxt == CNT_DONE) begin
            press_pulse = 1'b1;
            state_nxt   = HELD;
          end
        end else begin
          code_nxt = key_code;
          cnt_nxt  = CNT_ONE;
        end
      end
      HELD: begin
        // No auto-repeat: only a stable release re-arms the FSM.
        if (key == '0) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RELEASE;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      RELEASE: begin
        if (key == '0) begin
          cnt_nxt = cnt + CNT_ONE;
          if (cnt_nxt == CNT_DONE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          state_nxt = HELD;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign press_code = code_nxt;

endmodule
`default_nettype wire

// File: rtl/keypad_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : keypad_bcd_encoder
// Purpose  : Debounced 10-key keypad to three-digit BCD time entry.
//            Accepted digits enter at seconds-ones and shift left.
// Ports    : clk, rst_n (sync, active-low),
//            kp (keypad_if.slave): key, clear, lock in;
//            min, sec_tens, sec_ones, digit_strobe, time_valid out
// Revision : 1.0 - initial release
// ============================================================================
module keypad_bcd_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic     clk,
  input logic     rst_n,
  keypad_if.slave kp
);

  logic             press_pulse;
  logic [BCD_W-1:0] press_code;
  logic [BCD_W-1:0] min_q, tens_q, ones_q;
  logic             strobe_q;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (kp.key),
    .lock        (kp.lock),
    .press_pulse (press_pulse),
    .press_code  (press_code)
  );

  // clear wins over a same-edge commit; the FSM is untouched by clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (kp.clear) begin
        min_q  <= '0;
        tens_q <= '0;
        ones_q <= '0;
      end else if (press_pulse) begin
        min_q    <= tens_q;
        tens_q   <= ones_q;
        ones_q   <= press_code;
        strobe_q <= 1'b1;
      end
    end
  end

  assign kp.min          = min_q;
  assign kp.sec_tens     = tens_q;
  assign kp.sec_ones     = ones_q;
  assign kp.digit_strobe = strobe_q;
  assign kp.time_valid   = ({min_q, tens_q, ones_q} != '0) && (tens_q <= MAX_SEC_TENS);

endmodule
`default_nettype wire

// File: tb/tb_keypad_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_bcd_encoder
// Purpose  : Self-checking bench for keypad_bcd_encoder (DEBOUNCE_CYCLES=4).
//            Expected digit states are queued when a committing press is
//            driven and compared when digit_strobe is seen.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_bcd_encoder;

  localparam int N = 4;

  typedef struct {
    logic [3:0] mn;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       valid;
  } exp_t;

  logic clk;
  logic rst_n;
  keypad_if kp ();

  keypad_bcd_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int strobe_cnt = 0;
  int base;
  exp_t exp_q[$];
  logic [3:0] m_min, m_tens, m_ones;
  logic prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic model_valid();
    return ({m_min, m_tens, m_ones} != 12'h0) && (m_tens <= 4'd5);
  endfunction

  task automatic push_commit(input int d);
    exp_t e;
    m_min  = m_tens;
    m_tens = m_ones;
    m_ones = 4'(d);
    e.mn = m_min; e.tens = m_tens; e.ones = m_ones; e.valid = model_valid();
    exp_q.push_back(e);
  endtask

  task automatic press_digit(input int d, input int hold, input int rel);
    kp.key = 10'(1) << d;
    push_commit(d);
    tick(hold);
    kp.key = '0;
    tick(rel);
  endtask

  task automatic check_digits(input string tag);
    check({tag, "_min"},  32'(kp.min),        32'(m_min));
    check({tag, "_tens"}, 32'(kp.sec_tens),   32'(m_tens));
    check({tag, "_ones"}, 32'(kp.sec_ones),   32'(m_ones));
    check({tag, "_tv"},   32'(kp.time_valid), 32'(model_valid()));
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && kp.digit_strobe) begin
      exp_t e;
      strobe_cnt++;
      if (prev_strobe) check("strobe_width", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_min",  32'(kp.min),        32'(e.mn));
        check("sb_tens", 32'(kp.sec_tens),   32'(e.tens));
        check("sb_ones", 32'(kp.sec_ones),   32'(e.ones));
        check("sb_tv",   32'(kp.time_valid), 32'(e.valid));
      end
    end
    prev_strobe = kp.digit_strobe;
  end

  initial begin
    m_min = 0; m_tens = 0; m_ones = 0;
    rst_n = 1'b0; kp.key = 10'h002; kp.clear = 1'b0; kp.lock = 1'b0;

    // Reset with a key held, then release reset.
    tick(5);
    check("rst_strobe", 32'(kp.digit_strobe), 0);
    check_digits("rst");
    rst_n = 1'b1;
    push_commit(1);
    base = strobe_cnt;
    tick(N - 1);
    check("rst_early_strobe", 32'(kp.digit_strobe), 0);
    check("rst_early_cnt", 32'(strobe_cnt - base), 0);
    tick(1);
    check("rst_commit_strobe", 32'(kp.digit_strobe), 1);
    kp.key = '0;
    tick(6);
    kp.clear = 1'b1; tick(1); kp.clear = 1'b0;
    m_min = 0; m_tens = 0; m_ones = 0;
    check_digits("clear0");

    // 1, 3, 0.
    base = strobe_cnt;
    press_digit(1, 6, 6);
    press_digit(3, 6, 6);
    press_digit(0, 6, 6);
    check("entry_strobes", 32'(strobe_cnt - base), 3);
    check_digits("entry130");

    // Bounced press never reaches N stable samples.
    base = strobe_cnt;
    kp.key = 10'h020; tick(3);
    kp.key = '0;      tick(1);
    kp.key = 10'h020; tick(2);
    kp.key = '0;      tick(6);
    check("bounce_strobes", 32'(strobe_cnt - base), 0);
    check_digits("bounce");

    // Chord is ignored; long hold with a short release glitch commits once.
    base = strobe_cnt;
    kp.key = 10'b0000100100; tick(20);
    kp.key = '0; tick(2);
    check("multi_strobes", 32'(strobe_cnt - base), 0);
    kp.key = 10'(1) << 7;
    push_commit(7);
    tick(24);
    kp.key = '0; tick(2);
    kp.key = 10'(1) << 7; tick(24);
    kp.key = '0; tick(6);
    check("glitch_strobes", 32'(strobe_cnt - base), 1);
    check_digits("hold7");

    // Out-of-range seconds tens.
    press_digit(9, 6, 6);
    press_digit(9, 6, 6);
    check_digits("enter99");
    press_digit(2, 6, 6);
    check_digits("enter992");

    // clear on the commit edge; FSM still goes to HELD (no second commit).
    base = strobe_cnt;
    kp.key = 10'(1) << 4; tick(N - 1);
    kp.clear = 1'b1; tick(1);
    kp.clear = 1'b0;
    m_min = 0; m_tens = 0; m_ones = 0;
    check("clr_commit_strobe", 32'(kp.digit_strobe), 0);
    check_digits("clr_commit");
    tick(6);
    kp.key = '0; tick(6);
    check("clr_commit_cnt", 32'(strobe_cnt - base), 0);

    // lock on the 3rd and on the N-th press sample.
    base = strobe_cnt;
    kp.key = 10'(1) << 6; tick(2);
    kp.lock = 1'b1; tick(5);
    kp.key = '0; tick(2);
    kp.lock = 1'b0;
    kp.key = 10'(1) << 6; tick(N - 1);
    kp.lock = 1'b1; tick(1);
    check("lock_nth_strobe", 32'(kp.digit_strobe), 0);
    kp.key = '0; tick(2);
    kp.lock = 1'b0; tick(2);
    check("lock_strobes", 32'(strobe_cnt - base), 0);
    check_digits("lock");

    // Reset during PRESS.
    press_digit(8, 6, 6);
    check_digits("pre_rst");
    kp.key = 10'(1) << 3; tick(2);
    rst_n = 1'b0; tick(1);
    m_min = 0; m_tens = 0; m_ones = 0;
    check("mid_rst_strobe", 32'(kp.digit_strobe), 0);
    check_digits("mid_rst");
    kp.key = '0; rst_n = 1'b1; tick(6);
    base = strobe_cnt;
    kp.key = 10'(1) << 3;
    push_commit(3);
    tick(N - 1);
    check("post_rst_early", 32'(strobe_cnt - base), 0);
    tick(1);
    check("post_rst_commit", 32'(kp.digit_strobe), 1);
    kp.key = '0; tick(6);
    check_digits("post_rst");

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
